mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 217 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative MIPS HI/LO multiply/divide unit.
//
// A mult/multu/div/divu takes WIDTH+2 cycles, one bit per cycle. The
// operands are held as unsigned magnitudes and the signs are applied once
// at the end. mthi/mtlo/mfhi/mflo complete at the accepting edge in IDLE.
//
// Ports
//   clk     : sole clock, rising edge
//   reset   : synchronous, active-high
//   start   : request strobe; only accepted in IDLE with a known Funct
//   Funct   : MIPS R-type funct field selecting the operation
//   in_a    : rs operand (multiplicand / dividend / mthi, mtlo source)
//   in_b    : rt operand (multiplier / divisor)
//   busy    : high while a mult/div is in flight (RUN or FIX)
//   done    : one-cycle pulse when a mult/div writes HI/LO
//   result  : registered value of the last mfhi/mflo
//   hi, lo  : current HI and LO registers
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting; mt/mf ops execute here, mult/div is accepted here
// RUN   | one shift-add or restoring subtract-shift step per cycle
// FIX   | apply signs / divide-by-zero rule, write HI/LO, pulse done

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;

    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTLO = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    // acc: product high half while multiplying, partial remainder while dividing.
    // mq : multiplier bits shifting out (product low half shifting in),
    //      or dividend bits shifting out (quotient bits shifting in).
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    // Raw dividend, needed because divide-by-zero returns it unmodified in HI.
    logic [WIDTH-1:0] araw_q, araw_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             is_div_q, is_div_d;

    logic             is_muldiv;
    logic             op_signed;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [W2-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_comb begin
        is_muldiv = (Funct[5:2] == 4'b0110);
        op_signed = ~Funct[0];
        mag_a     = (op_signed && in_a[WIDTH-1]) ? (~in_a + WIDTH'(1)) : in_a;
        mag_b     = (op_signed && in_b[WIDTH-1]) ? (~in_b + WIDTH'(1)) : in_b;

        add_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        // Only used when div_ge, where the true difference fits in WIDTH bits.
        div_diff  = div_shift[WIDTH-1:0] - opb_q;

        prod      = {acc_q, mq_q};
        prod_fix  = (neg_a_q ^ neg_b_q) ? (~prod + W2'(1)) : prod;
        // Most-negative / -1 yields magnitude 2^(WIDTH-1) with positive sign,
        // which already reads back as the most-negative value.
        quo_fix   = (neg_a_q ^ neg_b_q) ? (~mq_q + WIDTH'(1)) : mq_q;
        rem_fix   = neg_a_q ? (~acc_q + WIDTH'(1)) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mq_d     = mq_q;
        opb_d    = opb_q;
        araw_d   = araw_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        is_div_d = is_div_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_muldiv) begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(WIDTH);
                        acc_d    = '0;
                        is_div_d = Funct[1];
                        mq_d     = Funct[1] ? mag_a : mag_b;
                        opb_d    = Funct[1] ? mag_b : mag_a;
                        araw_d   = in_a;
                        neg_a_d  = op_signed & in_a[WIDTH-1];
                        neg_b_d  = op_signed & in_b[WIDTH-1];
                    end else begin
                        case (Funct)
                            F_MTHI:  hi_d     = in_a;
                            F_MTLO:  lo_d     = in_a;
                            F_MFHI:  result_d = hi_q;
                            F_MFLO:  result_d = lo_q;
                            default: ;
                        endcase
                    end
                end
            end

            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = add_sum[WIDTH:1];
                    mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (opb_q == '0) begin
                        hi_d = araw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    hi_d = prod_fix[W2-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            mq_q     <= '0;
            opb_q    <= '0;
            araw_q   <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            opb_q    <= opb_d;
            araw_q   <= araw_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            is_div_q <= is_div_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32. Inputs change and outputs are
// sampled on the falling edge of clk.

module tb_mul_div_unit;

    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'b000000;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        busy, done;
    logic [31:0] result, hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int excl_err = 0;
    int dbl_err  = 0;
    logic done_prev = 1'b0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Funct  (funct),
        .in_a   (in_a),
        .in_b   (in_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && done) excl_err++;
        if (done && done_prev) dbl_err++;
        if (done) done_cnt++;
        done_prev = done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns at the falling edge after the accepting edge (edge 0).
    task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct = f;
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges until done is seen (bounded); checks HI/LO hold mid-run.
    task automatic wait_done(input string tag, input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                             output int n_edges, output int n_busy);
        n_edges = 0;
        n_busy  = 0;
        while (!done && n_edges < 100) begin
            if (busy) n_busy++;
            if (n_edges == 10) begin
                check({tag, "_hold_hi"}, hi, hold_hi);
                check({tag, "_hold_lo"}, lo, hold_lo);
            end
            @(negedge clk);
            n_edges++;
        end
    endtask

    task automatic mdu_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0, lo0;
        int e, nb;
        hi0 = hi;
        lo0 = lo;
        start_op(f, a, b);
        wait_done(tag, hi0, lo0, e, nb);
        check({tag, "_latency"}, 32'(e), 32'd33);
        check({tag, "_busy_cycles"}, 32'(nb), 32'd33);
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        @(negedge clk);
        check({tag, "_done_single"}, {31'b0, done}, 32'd0);
    endtask

    task automatic mt_mf(input logic [5:0] f, input logic [31:0] a);
        start_op(f, a, 32'h0);
    endtask

    initial begin
        int e, nb, d0;

        // Reset held while a mult start is presented: reset must win.
        funct = MULT;
        in_a  = 32'd5;
        in_b  = 32'd5;
        start = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_busy",   {31'b0, busy}, 32'd0);
        check("rst_done",   {31'b0, done}, 32'd0);
        check("rst_hi",     hi,     32'd0);
        check("rst_lo",     lo,     32'd0);
        check("rst_result", result, 32'd0);

        mdu_op("mult_m3x7",   MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        mdu_op("multu_max",   MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        mdu_op("div_m7d2",    DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        mdu_op("divu_7d0",    DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
        mdu_op("div_ovf",     DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        mdu_op("div_7dm2",    DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        mdu_op("div_m8d0",    DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF);
        mdu_op("mult_maxmin", MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
        mdu_op("multu_msb2",  MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000);

        mt_mf(MTHI, 32'h1234);
        check("mthi_hi", hi, 32'h1234);
        mt_mf(MFHI, 32'h0);
        check("mfhi_result", result, 32'h1234);
        check("mt_mf_busy", {31'b0, busy}, 32'd0);
        mt_mf(MTLO, 32'hABCD);
        mt_mf(MFLO, 32'h0);
        check("mflo_result", result, 32'hABCD);

        // Unknown funct (add) is ignored.
        start_op(6'b100000, 32'h9999, 32'h1);
        check("bad_funct_busy", {31'b0, busy}, 32'd0);
        check("bad_funct_hi",   hi, 32'h1234);
        check("bad_funct_lo",   lo, 32'hABCD);

        // Requests while busy are ignored, including a second mult.
        mt_mf(MTHI, 32'h5555);
        start_op(MULT, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        funct = MTHI;
        in_a  = 32'hDEAD;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mthi_busy_hi", hi, 32'h5555);
        funct = MFLO;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mflo_busy_result", result, 32'hABCD);
        funct = MULT;
        in_a  = 32'd9;
        in_b  = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ign", 32'h5555, 32'hABCD, e, nb);
        check("busy_ign_latency", 32'(e), 32'd26);
        check("busy_ign_hi", hi, 32'h0);
        check("busy_ign_lo", lo, 32'h6);
        mt_mf(MFLO, 32'h0);

        // Reset during iteration 10 of a mult discards it.
        start_op(MULT, 32'd5, 32'd5);
        repeat (9) @(negedge clk);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy",   {31'b0, busy}, 32'd0);
        check("midrst_hi",     hi,     32'd0);
        check("midrst_lo",     lo,     32'd0);
        check("midrst_result", result, 32'd0);
        repeat (40) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt), 32'(d0));
        check("midrst_hi_late", hi, 32'd0);

        mdu_op("divu_100d7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        check("busy_done_excl", 32'(excl_err), 32'd0);
        check("done_no_double", 32'(dbl_err),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
